// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register-file writeback arbiter for ALU results and in-order load returns
//
// Purpose: merges ALU results and returned load data into a single registered
// register-file write port. Loads are tracked in a 2-entry in-order pending
// FIFO; an ALU write to a register with a pending load marks that load dead so
// the newer ALU value is never overwritten.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   alu_valid/rd/value  ALU write request (rd 0 = no write)
//   load_issue/rd       allocate a pending load entry
//   load_issue_ready    a pending entry is free
//   load_ret_valid/value returned load data, in issue order
//   write_register/value registered register-file write (register 0 = idle)
//   busy_mask           registers with a live pending load
//   err_ret_unexpected  sticky: a return arrived with no entry awaiting data
module reg_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_value,
  input  logic        load_issue,
  input  logic [3:0]  load_rd,
  output logic        load_issue_ready,
  input  logic        load_ret_valid,
  input  logic [31:0] load_ret_value,
  output logic [4:0]  write_register,
  output logic [31:0] write_value,
  output logic [15:0] busy_mask,
  output logic        err_ret_unexpected
);

  // Entry 0 is always the head; the FIFO shifts down on pop.
  logic [1:0]       count;
  logic [1:0][3:0]  ent_rd;
  logic [1:0]       ent_has;
  logic [1:0][31:0] ent_data;
  logic [1:0]       ent_kill;

  logic [1:0]       n_count;
  logic [1:0][3:0]  n_rd, m_rd;
  logic [1:0]       n_has, m_has;
  logic [1:0][31:0] n_data, m_data;
  logic [1:0]       n_kill, m_kill;

  logic [1:0] valid;
  logic       alu_wr, head_ready, head_dead, load_wr, pop, issue, ret_hit, ret_miss, slot;

  assign load_issue_ready = (count != 2'd2);

  always_comb begin
    busy_mask = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      if (valid[i] && !ent_kill[i] && (ent_rd[i] != 4'd0)) busy_mask[ent_rd[i]] = 1'b1;
    end
  end

  always_comb begin
    valid[0]   = (count != 2'd0);
    valid[1]   = (count == 2'd2);
    alu_wr     = alu_valid && (alu_rd != 4'd0);
    head_ready = valid[0] && ent_has[0];
    head_dead  = ent_kill[0] || (ent_rd[0] == 4'd0);
    // ALU owns the write port; a dead head can still retire under it.
    load_wr    = head_ready && !alu_wr && !head_dead;
    pop        = head_ready && (!alu_wr || head_dead);
    issue      = load_issue && (count != 2'd2);

    m_rd   = ent_rd;
    m_has  = ent_has;
    m_data = ent_data;
    m_kill = ent_kill;

    // Kill only entries that already exist; a same-cycle issue stays live.
    for (int i = 0; i < 2; i++) begin
      if (valid[i] && alu_wr && (ent_rd[i] == alu_rd)) m_kill[i] = 1'b1;
    end

    ret_hit = 1'b0;
    if (load_ret_valid) begin
      if (valid[0] && !ent_has[0]) begin
        m_has[0]  = 1'b1;
        m_data[0] = load_ret_value;
        ret_hit   = 1'b1;
      end else if (valid[1] && !ent_has[1]) begin
        m_has[1]  = 1'b1;
        m_data[1] = load_ret_value;
        ret_hit   = 1'b1;
      end
    end
    ret_miss = load_ret_valid && !ret_hit;

    if (pop) begin
      n_rd   = {4'd0, m_rd[1]};
      n_has  = {1'b0, m_has[1]};
      n_data = {32'd0, m_data[1]};
      n_kill = {1'b0, m_kill[1]};
    end else begin
      n_rd   = m_rd;
      n_has  = m_has;
      n_data = m_data;
      n_kill = m_kill;
    end

    // Issue only happens with count < 2, so the free slot is 0 or 1.
    slot = count[0] && !pop;
    if (issue) begin
      n_rd[slot]   = load_rd;
      n_has[slot]  = 1'b0;
      n_data[slot] = 32'd0;
      n_kill[slot] = 1'b0;
    end

    n_count = count - {1'b0, pop} + {1'b0, issue};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count              <= 2'd0;
      ent_rd             <= '0;
      ent_has            <= '0;
      ent_data           <= '0;
      ent_kill           <= '0;
      write_register     <= 5'd0;
      write_value        <= 32'd0;
      err_ret_unexpected <= 1'b0;
    end else begin
      count    <= n_count;
      ent_rd   <= n_rd;
      ent_has  <= n_has;
      ent_data <= n_data;
      ent_kill <= n_kill;
      if (alu_wr) begin
        write_register <= {1'b0, alu_rd};
        write_value    <= alu_value;
      end else if (load_wr) begin
        write_register <= {1'b0, ent_rd[0]};
        write_value    <= ent_data[0];
      end else begin
        write_register <= 5'd0;
      end
      if (ret_miss) err_ret_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - self-checking bench for reg_writeback against a queue-based reference model
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_rd = 4'd0;
  logic [31:0] alu_value = 32'd0;
  logic        load_issue = 1'b0;
  logic [3:0]  load_rd = 4'd0;
  logic        load_issue_ready;
  logic        load_ret_valid = 1'b0;
  logic [31:0] load_ret_value = 32'd0;
  logic [4:0]  write_register;
  logic [31:0] write_value;
  logic [15:0] busy_mask;
  logic        err_ret_unexpected;

  reg_writeback dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value),
    .load_issue(load_issue), .load_rd(load_rd), .load_issue_ready(load_issue_ready),
    .load_ret_valid(load_ret_valid), .load_ret_value(load_ret_value),
    .write_register(write_register), .write_value(write_value),
    .busy_mask(busy_mask), .err_ret_unexpected(err_ret_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    bit          has;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  exp_wreg;
  logic [31:0] exp_wval;
  logic        exp_err;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] b = 16'h0;
    foreach (q[i]) if (!q[i].kill && q[i].rd != 4'd0) b[q[i].rd] = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_wreg = 5'd0;
    exp_wval = 32'd0;
    exp_err  = 1'b0;
  endtask

  // One clock edge of the rules, applied to the pre-edge queue and inputs.
  task automatic model_edge();
    bit   alu_wr = alu_valid && alu_rd != 4'd0;
    int   old = q.size();
    bit   found = 0;
    ent_t e;
    exp_wreg = 5'd0;
    if (alu_wr) begin
      exp_wreg = {1'b0, alu_rd};
      exp_wval = alu_value;
    end
    if (old > 0 && q[0].has) begin
      bit dead = q[0].kill || q[0].rd == 4'd0;
      if (!alu_wr && !dead) begin
        exp_wreg = {1'b0, q[0].rd};
        exp_wval = q[0].data;
      end
      if (!alu_wr || dead) void'(q.pop_front());
    end
    if (alu_wr) foreach (q[i]) if (q[i].rd == alu_rd) begin
      e = q[i]; e.kill = 1; q[i] = e;
    end
    if (load_ret_valid) begin
      foreach (q[i]) if (!found && !q[i].has) begin
        e = q[i]; e.has = 1; e.data = load_ret_value; q[i] = e; found = 1;
      end
      if (!found) exp_err = 1'b1;
    end
    if (load_issue && old < 2) begin
      e.rd = load_rd; e.has = 0; e.data = 32'd0; e.kill = 0;
      q.push_back(e);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wreg"}, {27'd0, write_register}, {27'd0, exp_wreg});
    chk({tag, ".wval"}, write_value, exp_wval);
    chk({tag, ".busy"}, {16'd0, busy_mask}, {16'd0, model_busy()});
    chk({tag, ".ready"}, {31'd0, load_issue_ready}, {31'd0, q.size() < 2});
    chk({tag, ".err"}, {31'd0, err_ret_unexpected}, {31'd0, exp_err});
  endtask

  task automatic cyc(input string tag, input logic av, input logic [3:0] ar, input logic [31:0] aval,
                     input logic li, input logic [3:0] lr, input logic rv, input logic [31:0] rval);
    alu_valid = av; alu_rd = ar; alu_value = aval;
    load_issue = li; load_rd = lr;
    load_ret_valid = rv; load_ret_value = rval;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 4'd0, 32'd0, 0, 4'd0, 0, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    chk("reset.ready1", {31'd0, load_issue_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // ALU write then idle
    cyc("alu5", 1, 4'd5, 32'h12345678, 0, 4'd0, 0, 32'd0);
    chk("alu5.reg", {27'd0, write_register}, 32'd5);
    chk("alu5.val", write_value, 32'h12345678);
    idle("alu5.after");
    chk("alu5.idle", {27'd0, write_register}, 32'd0);

    // single load to r3
    cyc("ld3.issue", 0, 4'd0, 32'd0, 1, 4'd3, 0, 32'd0);
    chk("ld3.busy", {16'd0, busy_mask}, 32'h8);
    idle("ld3.w1");
    idle("ld3.w2");
    cyc("ld3.ret", 0, 4'd0, 32'd0, 0, 4'd0, 1, 32'hCAFEBABE);
    chk("ld3.notyet", {27'd0, write_register}, 32'd0);
    idle("ld3.drain");
    chk("ld3.reg", {27'd0, write_register}, 32'd3);
    chk("ld3.val", write_value, 32'hCAFEBABE);
    chk("ld3.busy0", {16'd0, busy_mask}, 32'h0);

    // two loads fill the FIFO, third ignored, in-order writeback
    cyc("fill.1", 0, 4'd0, 32'd0, 1, 4'd1, 0, 32'd0);
    cyc("fill.2", 0, 4'd0, 32'd0, 1, 4'd2, 0, 32'd0);
    chk("fill.notready", {31'd0, load_issue_ready}, 32'd0);
    cyc("fill.3", 0, 4'd0, 32'd0, 1, 4'd9, 0, 32'd0);
    chk("fill.busy", {16'd0, busy_mask}, 32'h6);
    cyc("fill.retA", 0, 4'd0, 32'd0, 0, 4'd0, 1, 32'hAAAA0001);
    cyc("fill.retB", 0, 4'd0, 32'd0, 0, 4'd0, 1, 32'hBBBB0002);
    chk("fill.reg1", {27'd0, write_register}, 32'd1);
    chk("fill.valA", write_value, 32'hAAAA0001);
    idle("fill.drainB");
    chk("fill.reg2", {27'd0, write_register}, 32'd2);
    chk("fill.valB", write_value, 32'hBBBB0002);
    idle("fill.empty");

    // WAW: ALU overrides pending load to r4
    cyc("waw.issue", 0, 4'd0, 32'd0, 1, 4'd4, 0, 32'd0);
    cyc("waw.alu", 1, 4'd4, 32'h11, 0, 4'd0, 0, 32'd0);
    chk("waw.reg", {27'd0, write_register}, 32'd4);
    chk("waw.busy", {16'd0, busy_mask}, 32'h0);
    cyc("waw.ret", 0, 4'd0, 32'd0, 0, 4'd0, 1, 32'h99);
    idle("waw.drop");
    chk("waw.nowrite", {27'd0, write_register}, 32'd0);
    chk("waw.val", write_value, 32'h11);

    // load data held behind three ALU cycles
    cyc("hold.issue", 0, 4'd0, 32'd0, 1, 4'd6, 0, 32'd0);
    cyc("hold.ret", 0, 4'd0, 32'd0, 0, 4'd0, 1, 32'hD00DF00D);
    for (int i = 0; i < 3; i++) begin
      cyc("hold.alu", 1, 4'd7, 32'h700 + i, 0, 4'd0, 0, 32'd0);
      chk("hold.alureg", {27'd0, write_register}, 32'd7);
    end
    idle("hold.drain");
    chk("hold.reg", {27'd0, write_register}, 32'd6);
    chk("hold.val", write_value, 32'hD00DF00D);

    // unexpected return, sticky error, reset mid-load
    cyc("err.ret", 0, 4'd0, 32'd0, 0, 4'd0, 1, 32'h5);
    chk("err.set", {31'd0, err_ret_unexpected}, 32'd1);
    idle("err.sticky");
    cyc("mid.issue", 0, 4'd0, 32'd0, 1, 4'd8, 0, 32'd0);
    cyc("mid.ret", 0, 4'd0, 32'd0, 0, 4'd0, 1, 32'h88);
    do_reset("mid.rst");
    chk("mid.rst.busy", {16'd0, busy_mask}, 32'h0);
    chk("mid.rst.err", {31'd0, err_ret_unexpected}, 32'd0);
    idle("mid.nowrite");
    chk("mid.nowrite.reg", {27'd0, write_register}, 32'd0);
    cyc("mid.lateret", 0, 4'd0, 32'd0, 0, 4'd0, 1, 32'h77);
    chk("mid.lateret.err", {31'd0, err_ret_unexpected}, 32'd1);

    // randomized traffic against the model
    do_reset("rand.rst");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rand.rst");
      cyc("rand",
          $urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)),
          $urandom_range(0, 2) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: alu_valid  input  1  ALU result write request this cycle.
REQ-004 SHALL have ports: alu_rd  input  4  ALU destination register; 0 = no architectural write.
REQ-005 SHALL have ports: alu_value  input  32  ALU result.
REQ-006 SHALL have ports: load_issue  input  1  load issued; allocates a pending entry.
REQ-007 SHALL have ports: load_rd  input  4  load destination register.
REQ-008 SHALL have ports: load_issue_ready  output  1  high when a pending entry is free.
REQ-009 SHALL have ports: load_ret_valid  input  1  load data returned; loads return in issue order.
REQ-010 SHALL have ports: load_ret_value  input  32  returned load data.
REQ-011 SHALL have ports: write_register  output  5  register-file write index, registered; 0 = no write.
REQ-012 SHALL have ports: write_value  output  32  register-file write data, registered.
REQ-013 SHALL have ports: busy_mask  output  16  bit n high while a live load to register n is pending.
REQ-014 SHALL have ports: err_ret_unexpected  output  1  sticky; return seen with no entry awaiting data.

Function
REQ-015 SHALL hold a 2-entry in-order pending-load FIFO; each entry: rd[3:0], has_data, data[31:0], kill.
REQ-016 SHALL drive load_issue_ready = (entry count < 2), combinational from registered state.
REQ-017 SHALL allocate an entry (rd=load_rd, has_data=0, kill=0) on load_issue && load_issue_ready; load_issue while not ready SHALL be ignored.
REQ-018 SHALL on load_ret_valid store load_ret_value into the oldest entry with has_data=0 and set its has_data; if none exists the return SHALL be dropped and err_ret_unexpected set.
REQ-019 SHALL give ALU priority: alu_valid with alu_rd!=0 at edge k drives write_register={0,alu_rd}, write_value=alu_value from edge k.
REQ-020 SHALL, in a cycle with no ALU write (alu_valid=0 or alu_rd=0), drain the head entry if has_data=1: pop it and, if kill=0 and rd!=0, drive write_register={0,rd}, write_value=data at that edge.
REQ-021 SHALL pop a head entry with has_data=1 and kill=1 (or rd=0) without producing a write, in any cycle including ALU-write cycles.
REQ-022 SHALL drive write_register=0 at each edge where no write is produced; write_value SHALL hold its previous value.
REQ-023 SHALL latency: ALU write visible 1 edge after request; load data returned at edge k written no earlier than edge k+1.
REQ-024 SHALL on an ALU write to rd set kill on every existing entry with matching rd (WAW: ALU value wins); a load issued in the same cycle to the same rd SHALL NOT be killed.
REQ-025 SHALL compute busy_mask combinationally as OR of one-hot(rd) over valid entries with kill=0 and rd!=0.
REQ-026 SHALL support simultaneous issue, return and drain in one cycle; count SHALL update as count + issue - pop.
REQ-027 SHALL never produce a write to register 0.

Reset
REQ-028 SHALL on rst high immediately clear FIFO (count=0, all fields 0), write_register=0, write_value=0, err_ret_unexpected=0; busy_mask=0, load_issue_ready=1.
REQ-029 SHALL discard pending loads and in-flight writes when rst asserts mid-operation; returns after reset release with no entry SHALL set err_ret_unexpected.

Verification
REQ-030 SHALL test: alu_valid, alu_rd=5, alu_value=0x12345678 -> next edge write_register=5, write_value=0x12345678, then write_register=0.
REQ-031 SHALL test: load_issue rd=3; return 0xCAFEBABE two cycles later, no ALU -> busy_mask=0x0008 until write of 0xCAFEBABE to reg 3 one edge after return, then busy_mask=0.
REQ-032 SHALL test: two loads issued (rd=1, rd=2) -> load_issue_ready=0; third issue ignored; returns A,B -> writes reg1=A then reg2=B in order.
REQ-033 SHALL test: pending load rd=4, ALU write rd=4 value 0x11 -> reg4=0x11 written, busy_mask bit4 clears, later return for reg4 produces no write.
REQ-034 SHALL test: load data held while ALU writes rd=7 for 3 consecutive cycles -> load write to its rd occurs on the first ALU-free edge.
REQ-035 SHALL test: load_ret_valid with empty FIFO -> err_ret_unexpected=1 and stays set; rst pulse mid-load -> all outputs at reset values, no write emitted.
